// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/result bundle between the execute stage and the shift sequencer.
interface shift_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned SW = $clog2(WIDTH);

  logic             ctrl_start;
  logic             ctrl_cancel;
  logic [1:0]       ctrl_op;
  logic [WIDTH-1:0] data_operand;
  logic [SW-1:0]    data_shamt;
  logic [WIDTH-1:0] data_result;
  logic             data_resultRDY;
  logic             data_exception;
  logic             busy;

  // Requester side (pipeline / bench)
  modport master (
    output ctrl_start, ctrl_cancel, ctrl_op, data_operand, data_shamt,
    input  data_result, data_resultRDY, data_exception, busy
  );

  // Sequencer side
  modport slave (
    input  ctrl_start, ctrl_cancel, ctrl_op, data_operand, data_shamt,
    output data_result, data_resultRDY, data_exception, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle SLL/SRL/SRA controller applying one power-of-two step per cycle.
// Optional feature macro SHIFT_ROTATE_EN: op 11 becomes rotate-right instead of an illegal op.
module shift_sequencer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_STEP = 16
) (
  input logic              clock,
  input logic              reset_n,
  shift_sequencer_if.slave bus
);
  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

`ifdef SHIFT_ROTATE_EN
  localparam bit ROTATE_EN = 1'b1;
`else
  localparam bit ROTATE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SW-1:0]    rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic             sign_q, sign_d;
  logic [SW-1:0]    step;
  logic [WIDTH-1:0] stepped;

  logic [WIDTH-1:0] result_q;
  logic             rdy_q;
  logic             exc_q;
  logic             busy_q;

  function automatic logic is_illegal(input logic [1:0] op);
    return (op == OP_ROR) && !ROTATE_EN;
  endfunction

  // Step size: highest set bit of the remaining count, capped at MAX_STEP
  always_comb begin
    step = '0;
    for (int unsigned i = 0; i < SW; i++) begin
      if (rem_q[i]) step = SW'(1) << i;
    end
    if (step > SW'(MAX_STEP)) step = SW'(MAX_STEP);
  end

  // One shift step of the working register; SRA fills with the sign captured at accept
  always_comb begin
    stepped = work_q;
    case (op_q)
      OP_SLL:  stepped = work_q << step;
      OP_SRL:  stepped = work_q >> step;
      OP_SRA:  stepped = (work_q >> step) | ({WIDTH{sign_q}} & ~({WIDTH{1'b1}} >> step));
`ifdef SHIFT_ROTATE_EN
      OP_ROR:  stepped = (work_q >> step) | (work_q << ((SW+1)'(WIDTH) - (SW+1)'(step)));
`endif
      default: stepped = work_q;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    op_d    = op_q;
    sign_d  = sign_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ctrl_start && !bus.ctrl_cancel) begin
          work_d  = bus.data_operand;
          rem_d   = bus.data_shamt;
          op_d    = bus.ctrl_op;
          sign_d  = bus.data_operand[WIDTH-1];
          state_d = ((bus.data_shamt == '0) || is_illegal(bus.ctrl_op)) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ctrl_cancel) begin
          state_d = IDLE;
        end else begin
          work_d = stepped;
          rem_d  = rem_q - step;
          if (rem_q == step) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and working registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

  // Registered outputs, aligned with the state they describe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      rdy_q    <= 1'b0;
      exc_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rdy_q  <= (state_d == DONE);
      exc_q  <= (state_d == DONE) && is_illegal(op_d);
      busy_q <= (state_d != IDLE);
      if (state_d == DONE) result_q <= work_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.data_exception = exc_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: drives identical requests into a MAX_STEP=16 and a MAX_STEP=1 sequencer
// and checks cycle-by-cycle busy/ready/exception/result against an arithmetic reference.
module tb_shift_sequencer;
  logic clock = 1'b0;
  logic reset_n;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] res_prev [2];

  always #5 clock = ~clock;

  shift_sequencer_if #(.WIDTH(32)) bus16 ();
  shift_sequencer_if #(.WIDTH(32)) bus1 ();

  shift_sequencer #(.WIDTH(32), .MAX_STEP(16)) dut16 (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus16)
  );

  shift_sequencer #(.WIDTH(32), .MAX_STEP(1)) dut1 (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus1)
  );

  function automatic logic ref_illegal(input logic [1:0] op);
`ifdef SHIFT_ROTATE_EN
    return (op == 2'b11) && 1'b0;
`else
    return (op == 2'b11);
`endif
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] x,
                                             input int s);
    logic signed [31:0] sx;
    sx = x;
    case (op)
      2'b00:   return x << s;
      2'b01:   return x >> s;
      2'b10:   return 32'(sx >>> s);
      default: begin
`ifdef SHIFT_ROTATE_EN
        if (s == 0) return x;
        return (x >> s) | (x << (32 - s));
`else
        return x;
`endif
      end
    endcase
  endfunction

  // Number of per-cycle steps: greedy powers of two capped at max_step
  function automatic int ref_steps(input logic [1:0] op, input int s, input int max_step);
    int r;
    int n;
    if (ref_illegal(op)) return 0;
    r = s;
    n = 0;
    while (r > 0) begin
      int p;
      p = 1;
      while (p * 2 <= r && p * 2 <= max_step) p = p * 2;
      r = r - p;
      n++;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic ca, input logic [1:0] op,
                       input logic [31:0] x, input logic [4:0] s);
    bus16.ctrl_start = st; bus16.ctrl_cancel = ca; bus16.ctrl_op = op;
    bus16.data_operand = x; bus16.data_shamt = s;
    bus1.ctrl_start = st;  bus1.ctrl_cancel = ca;  bus1.ctrl_op = op;
    bus1.data_operand = x;  bus1.data_shamt = s;
  endtask

  task automatic check_out(input int d, input string tag, input logic eb, input logic er,
                           input logic ee, input logic [31:0] eres);
    logic [31:0] r;
    logic b, y, e;
    if (d == 0) begin
      r = bus16.data_result; b = bus16.busy; y = bus16.data_resultRDY; e = bus16.data_exception;
    end else begin
      r = bus1.data_result;  b = bus1.busy;  y = bus1.data_resultRDY;  e = bus1.data_exception;
    end
    check({tag, " busy"}, 32'(b), 32'(eb));
    check({tag, " rdy"},  32'(y), 32'(er));
    check({tag, " exc"},  32'(e), 32'(ee));
    check({tag, " res"},  r, eres);
  endtask

  // Accept one request on both sequencers and check every cycle until both are idle again
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] x,
                        input logic [4:0] s);
    int n [2];
    int last;
    logic [31:0] exp;
    logic ex;
    exp  = ref_result(op, x, int'(s));
    ex   = ref_illegal(op);
    n[0] = ref_steps(op, int'(s), 16);
    n[1] = ref_steps(op, int'(s), 1);
    last = ((n[0] > n[1]) ? n[0] : n[1]) + 2;
    @(negedge clock);
    drive(1'b1, 1'b0, op, x, s);
    @(negedge clock);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    for (int k = 1; k <= last; k++) begin
      for (int d = 0; d < 2; d++) begin
        check_out(d, $sformatf("%s dut%0d c%0d", name, d, k),
                  k <= n[d] + 1, k == n[d] + 1, (k == n[d] + 1) && ex,
                  (k >= n[d] + 1) ? exp : res_prev[d]);
      end
      if (k < last) @(negedge clock);
    end
    res_prev[0] = exp;
    res_prev[1] = exp;
  endtask

  initial begin
    res_prev[0] = '0;
    res_prev[1] = '0;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    repeat (2) @(negedge clock);
    for (int d = 0; d < 2; d++) check_out(d, $sformatf("reset dut%0d", d), 1'b0, 1'b0, 1'b0, 32'h0);
    reset_n = 1'b1;

    run_op("t1_sll",   2'b00, 32'h0000_0001, 5'd5);
    // Reset pulse mid-shift: outputs drop at once, previous result cleared
    @(negedge clock);
    drive(1'b1, 1'b0, 2'b00, 32'h0000_0003, 5'd31);
    @(negedge clock);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) check_out(d, $sformatf("rstmid dut%0d", d), 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    res_prev[0] = '0;
    res_prev[1] = '0;

    run_op("t2_sra",   2'b10, 32'h8000_0000, 5'd31);
    run_op("t2_srl",   2'b01, 32'h8000_0000, 5'd31);
    run_op("t3_zero",  2'b01, 32'h1234_5678, 5'd0);
    run_op("t4_sll31", 2'b00, 32'hFFFF_FFFF, 5'd31);

    // Cancel during SHIFT, with a start in the same cycle that must be ignored
    @(negedge clock);
    drive(1'b1, 1'b0, 2'b10, 32'hF000_0000, 5'd8);
    @(negedge clock);
    drive(1'b1, 1'b1, 2'b10, 32'hF000_0000, 5'd8);
    for (int d = 0; d < 2; d++)
      check_out(d, $sformatf("t5_cancel dut%0d c1", d), 1'b1, 1'b0, 1'b0, res_prev[d]);
    @(negedge clock);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    for (int d = 0; d < 2; d++)
      check_out(d, $sformatf("t5_cancel dut%0d c2", d), 1'b0, 1'b0, 1'b0, res_prev[d]);
    @(negedge clock);
    for (int d = 0; d < 2; d++)
      check_out(d, $sformatf("t5_cancel dut%0d c3", d), 1'b0, 1'b0, 1'b0, res_prev[d]);
    run_op("t5_fresh", 2'b00, 32'h0000_0001, 5'd1);

    // Cancel together with start in IDLE: nothing accepted
    @(negedge clock);
    drive(1'b1, 1'b1, 2'b00, 32'h0000_00FF, 5'd3);
    @(negedge clock);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    for (int d = 0; d < 2; d++)
      check_out(d, $sformatf("idle_cancel dut%0d", d), 1'b0, 1'b0, 1'b0, res_prev[d]);

    run_op("t6_op11",  2'b11, 32'hDEAD_BEEF, 5'd4);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  rop;
      logic [31:0] rx;
      logic [4:0]  rs;
      rop = 2'($urandom_range(0, 3));
      rx  = $urandom;
      rs  = 5'($urandom_range(0, 31));
      run_op($sformatf("rnd%0d", i), rop, rx, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
